// File: rtl/cnt163_param.sv
// rtl/cnt163_param.sv - parameterised 74x163-style synchronous up/down modulus counter
// Priority per edge: clear, load, count, hold; rco is combinational for cascading.
module cnt163_param #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("cnt163_param: WIDTH must be in 2..32");
        end
        if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("cnt163_param: MODULUS must be in 2..2^WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    // One extra bit so the range test stays meaningful when MODULUS == 2^WIDTH.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);

    logic             at_zero;
    logic             at_term;
    logic             in_range;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    always_comb begin
        at_zero  = (q == '0);
        at_term  = (q == TERM);
        in_range = ({1'b0, q} < MOD_W);
        rco      = ent & (up ? at_term : at_zero);
    end

    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (!clr_n) begin
            next_q = '0;
        end else if (!load_n) begin
            next_q = d;
        end else if (enp && ent) begin
            if (up) begin
                // Out-of-range values fold to zero silently; only TERM wraps.
                if (in_range && !at_term) begin
                    next_q = q + ONE;
                end else begin
                    next_q    = '0;
                    next_wrap = at_term;
                end
            end else begin
                if (at_zero) begin
                    next_q    = TERM;
                    next_wrap = 1'b1;
                end else if (in_range) begin
                    next_q = q - ONE;
                end else begin
                    next_q = TERM;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_cnt163_param.sv
// tb/tb_cnt163_param.sv - self-checking bench for cnt163_param
// Instances: MOD16 (a), decade (b), two-stage decade cascade (c0/c1).
module tb_cnt163_param;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_clr_n, a_load_n, a_enp, a_ent, a_up, a_rco, a_wrap;
    logic [3:0] a_d, a_q;
    logic       b_clr_n, b_load_n, b_enp, b_ent, b_up, b_rco, b_wrap;
    logic [3:0] b_d, b_q;
    logic       c_clr_n, c_load_n, c_enp, c_ent, c_up;
    logic [3:0] c_d, c0_q, c1_q;
    logic       c0_rco, c1_rco, c0_wrap, c1_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnt163_param #(.WIDTH(4), .MODULUS(16)) u_a (
        .clk(clk), .rst_n(rst_n), .clr_n(a_clr_n), .load_n(a_load_n), .enp(a_enp),
        .ent(a_ent), .up(a_up), .d(a_d), .q(a_q), .rco(a_rco), .wrap(a_wrap));

    cnt163_param #(.WIDTH(4), .MODULUS(10)) u_b (
        .clk(clk), .rst_n(rst_n), .clr_n(b_clr_n), .load_n(b_load_n), .enp(b_enp),
        .ent(b_ent), .up(b_up), .d(b_d), .q(b_q), .rco(b_rco), .wrap(b_wrap));

    cnt163_param #(.WIDTH(4), .MODULUS(10)) u_c0 (
        .clk(clk), .rst_n(rst_n), .clr_n(c_clr_n), .load_n(c_load_n), .enp(c_enp),
        .ent(c_ent), .up(c_up), .d(c_d), .q(c0_q), .rco(c0_rco), .wrap(c0_wrap));

    cnt163_param #(.WIDTH(4), .MODULUS(10)) u_c1 (
        .clk(clk), .rst_n(rst_n), .clr_n(c_clr_n), .load_n(c_load_n), .enp(c_enp),
        .ent(c0_rco), .up(c_up), .d(c_d), .q(c1_q), .rco(c1_rco), .wrap(c1_wrap));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic void ref_step(input int q, input int m, input bit clr_n, input bit load_n,
                                     input bit enp, input bit ent, input bit up, input int d,
                                     output int nq, output bit w);
        w  = 1'b0;
        nq = q;
        if (!clr_n) nq = 0;
        else if (!load_n) nq = d;
        else if (enp && ent) begin
            if (up) begin
                w  = (q == m - 1);
                nq = (q < m - 1) ? q + 1 : 0;
            end else if (q == 0) begin
                nq = m - 1;
                w  = 1'b1;
            end else begin
                nq = (q < m) ? q - 1 : m - 1;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (a_q !== 4'd0 || a_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: q=%0d wrap=%b, expected q=0 wrap=0", a_q, a_wrap);
        end
        n_checks++;
        if (b_q !== 4'd0 || b_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: q=%0d wrap=%b, expected q=0 wrap=0", b_q, b_wrap);
        end
        a_ent = 1'b1; a_up = 1'b0; #1;
        n_checks++;
        if (a_rco !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rco_down: rco=%b, expected 1", a_rco);
        end
        a_up = 1'b1; #1;
        n_checks++;
        if (a_rco !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rco_up: rco=%b, expected 0", a_rco);
        end
    endtask

    task automatic test_count16();
        a_up = 1'b1; a_enp = 1'b1; a_ent = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            n_checks++;
            if (a_q !== 4'(i % 16) || a_rco !== (i % 16 == 15) || a_wrap !== (i == 16)) begin
                n_fail++;
                $display("FAIL count16[%0d]: q=%0d rco=%b wrap=%b, expected q=%0d rco=%b wrap=%b",
                         i, a_q, a_rco, a_wrap, i % 16, (i % 16 == 15), (i == 16));
            end
        end
        a_enp = 1'b0;
    endtask

    task automatic test_decade();
        int  exp_q [6] = '{12, 0, 1, 0, 9, 9};
        bit  exp_w [6] = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            b_clr_n = 1'b1; b_load_n = 1'b1; b_enp = 1'b1; b_ent = 1'b1; b_up = 1'b1;
            case (i)
                0: begin b_load_n = 1'b0; b_d = 4'd12; end
                3: b_clr_n = 1'b0;
                4: b_up = 1'b0;
                5: begin b_up = 1'b0; b_load_n = 1'b0; b_d = 4'd13; tick(); b_load_n = 1'b1; end
                default: ;
            endcase
            tick();
            n_checks++;
            if (b_q !== 4'(exp_q[i]) || b_wrap !== exp_w[i]) begin
                n_fail++;
                $display("FAIL decade[%0d]: q=%0d wrap=%b, expected q=%0d wrap=%b",
                         i, b_q, b_wrap, exp_q[i], exp_w[i]);
            end
        end
        b_enp = 1'b0;
    endtask

    task automatic test_priority();
        b_clr_n = 1'b0; b_load_n = 1'b0; b_d = 4'd5; b_enp = 1'b1; b_ent = 1'b1; b_up = 1'b1;
        tick();
        n_checks++;
        if (b_q !== 4'd0) begin
            n_fail++;
            $display("FAIL prio_clear: q=%0d, expected 0", b_q);
        end
        b_clr_n = 1'b1; b_enp = 1'b0;
        tick();
        n_checks++;
        if (b_q !== 4'd5) begin
            n_fail++;
            $display("FAIL prio_load: q=%0d, expected 5", b_q);
        end
        b_load_n = 1'b1; b_enp = 1'b1; b_ent = 1'b0;
        tick();
        n_checks++;
        if (b_q !== 4'd5 || b_rco !== 1'b0 || b_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_hold: q=%0d rco=%b wrap=%b, expected q=5 rco=0 wrap=0",
                     b_q, b_rco, b_wrap);
        end
        b_enp = 1'b0;
    endtask

    task automatic test_dir_toggle();
        b_clr_n = 1'b0; tick();
        b_clr_n = 1'b1; b_enp = 1'b1; b_ent = 1'b1; b_up = 1'b1;
        tick();
        n_checks++;
        if (b_q !== 4'd1 || b_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_up: q=%0d wrap=%b, expected q=1 wrap=0", b_q, b_wrap);
        end
        b_clr_n = 1'b0; tick();
        b_clr_n = 1'b1; b_up = 1'b0;
        tick();
        n_checks++;
        if (b_q !== 4'd9 || b_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_down: q=%0d wrap=%b, expected q=9 wrap=1", b_q, b_wrap);
        end
        b_enp = 1'b0;
    endtask

    task automatic test_async_reset();
        a_load_n = 1'b0; a_d = 4'd7;
        tick();
        a_load_n = 1'b1; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
        n_checks++;
        if (a_q !== 4'd7) begin
            n_fail++;
            $display("FAIL async_load: q=%0d, expected 7", a_q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_q !== 4'd0 || a_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: q=%0d wrap=%b, expected q=0 wrap=0", a_q, a_wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (a_q !== 4'd1) begin
            n_fail++;
            $display("FAIL async_resume: q=%0d, expected 1", a_q);
        end
        a_enp = 1'b0;
    endtask

    task automatic test_cascade();
        int wraps1 = 0;
        c_clr_n = 1'b1; c_load_n = 1'b1; c_enp = 1'b1; c_ent = 1'b1; c_up = 1'b1; c_d = 4'd0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (c1_wrap === 1'b1) wraps1++;
            n_checks++;
            if (c0_q !== 4'(i % 10) || c1_q !== 4'((i / 10) % 10) || c0_wrap !== (i % 10 == 0)) begin
                n_fail++;
                $display("FAIL cascade[%0d]: q1:q0=%0d:%0d w0=%b, expected %0d:%0d w0=%b",
                         i, c1_q, c0_q, c0_wrap, (i / 10) % 10, i % 10, (i % 10 == 0));
            end
        end
        n_checks++;
        if (c1_q !== 4'd0 || c0_q !== 4'd0 || wraps1 != 1) begin
            n_fail++;
            $display("FAIL cascade_end: q1:q0=%0d:%0d wraps1=%0d, expected 0:0 wraps1=1",
                     c1_q, c0_q, wraps1);
        end
        c_enp = 1'b0;
    endtask

    task automatic test_random();
        int ma, mb, na, nb;
        bit wa, wb;
        a_clr_n = 1'b0; b_clr_n = 1'b0; a_load_n = 1'b1; b_load_n = 1'b1;
        tick();
        ma = 0; mb = 0;
        for (int i = 0; i < 400; i++) begin
            a_clr_n = ($urandom_range(0, 15) != 0); a_load_n = ($urandom_range(0, 7) != 0);
            a_enp = ($urandom_range(0, 3) != 0); a_ent = ($urandom_range(0, 3) != 0);
            a_up = $urandom_range(0, 1) != 0; a_d = 4'($urandom_range(0, 15));
            b_clr_n = ($urandom_range(0, 15) != 0); b_load_n = ($urandom_range(0, 7) != 0);
            b_enp = ($urandom_range(0, 3) != 0); b_ent = ($urandom_range(0, 3) != 0);
            b_up = $urandom_range(0, 1) != 0; b_d = 4'($urandom_range(0, 15));
            #1;
            n_checks++;
            if (a_rco !== (a_ent && (a_up ? ma == 15 : ma == 0)) ||
                b_rco !== (b_ent && (b_up ? mb == 9 : mb == 0))) begin
                n_fail++;
                $display("FAIL rand_rco[%0d]: a=%b b=%b, expected a=%b b=%b", i, a_rco, b_rco,
                         (a_ent && (a_up ? ma == 15 : ma == 0)), (b_ent && (b_up ? mb == 9 : mb == 0)));
            end
            ref_step(ma, 16, a_clr_n, a_load_n, a_enp, a_ent, a_up, int'(a_d), na, wa);
            ref_step(mb, 10, b_clr_n, b_load_n, b_enp, b_ent, b_up, int'(b_d), nb, wb);
            ma = na; mb = nb;
            tick();
            n_checks++;
            if (a_q !== 4'(ma) || a_wrap !== wa || b_q !== 4'(mb) || b_wrap !== wb) begin
                n_fail++;
                $display("FAIL rand_q[%0d]: a=%0d/%b b=%0d/%b, expected a=%0d/%b b=%0d/%b",
                         i, a_q, a_wrap, b_q, b_wrap, ma, wa, mb, wb);
            end
        end
        a_enp = 1'b0; b_enp = 1'b0; a_clr_n = 1'b1; b_clr_n = 1'b1;
    endtask

    initial begin
        a_clr_n = 1'b1; a_load_n = 1'b1; a_enp = 1'b0; a_ent = 1'b0; a_up = 1'b1; a_d = 4'd0;
        b_clr_n = 1'b1; b_load_n = 1'b1; b_enp = 1'b0; b_ent = 1'b0; b_up = 1'b1; b_d = 4'd0;
        c_clr_n = 1'b1; c_load_n = 1'b1; c_enp = 1'b0; c_ent = 1'b0; c_up = 1'b1; c_d = 4'd0;
        test_reset();
        test_count16();
        test_decade();
        test_priority();
        test_dir_toggle();
        test_async_reset();
        test_cascade();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt163_param.md
CNT163_PARAM -- requirements
Module: cnt163_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter bit width (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count modulus (legal range 2..2^WIDTH; 10 gives decade operation).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clr_n, input, 1 bit: synchronous clear, active low.
REQ-006 The block SHALL have port load_n, input, 1 bit: synchronous parallel load, active low.
REQ-007 The block SHALL have port enp, input, 1 bit: count enable P.
REQ-008 The block SHALL have port ent, input, 1 bit: count enable T, also the cascade carry-in.
REQ-009 The block SHALL have port up, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-010 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered count value.
REQ-012 The block SHALL have port rco, output, 1 bit: ripple carry out, combinational.
REQ-013 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a modulus wrap.

Function
REQ-014 Each rising clk edge SHALL apply exactly one action, in this priority: clear (clr_n=0) -> load (load_n=0) -> count (enp=1 and ent=1) -> hold.
REQ-015 Clear SHALL set q to 0, regardless of enp, ent, up and d.
REQ-016 Load SHALL set q to d, including d values >= MODULUS (no saturation or masking).
REQ-017 Up-count SHALL set q to q+1 when q < MODULUS-1, and to 0 when q >= MODULUS-1.
REQ-018 Down-count SHALL set q to q-1 when 0 < q <= MODULUS-1, to MODULUS-1 when q = 0, and to MODULUS-1 when q >= MODULUS.
REQ-019 Hold SHALL leave q unchanged; enp=0 or ent=0 alone blocks counting.
REQ-020 The terminal state SHALL be q = MODULUS-1 when up=1 and q = 0 when up=0.
REQ-021 rco SHALL equal ent AND (q is at the terminal state for the current up value), independent of enp, clr_n and load_n.
REQ-022 rco SHALL follow up and ent combinationally within the same cycle, so that rco of stage k drives ent of stage k+1 for cascades.
REQ-023 wrap SHALL be 1 for exactly the cycle after an edge on which a count action moved q from the terminal state (0 -> MODULUS-1 down, MODULUS-1 -> 0 up).
REQ-024 wrap SHALL be 0 after any other action; out-of-range corrections in REQ-017/018 SHALL NOT assert wrap.
REQ-025 Counting latency SHALL be one cycle: q reflects an action on the edge where it is sampled.
REQ-026 All arithmetic SHALL be WIDTH bits, with no intermediate overflow visible on q.
REQ-027 Changing up on the same edge as a count SHALL count in the newly sampled direction.
REQ-028 A MODULUS outside its legal range SHALL be rejected at elaboration.

Reset
REQ-029 rst_n=0 SHALL asynchronously force q=0 and wrap=0, without waiting for clk.
REQ-030 While rst_n=0, rco SHALL still follow REQ-021 with q=0.
REQ-031 Deassertion of rst_n SHALL take effect at the first rising clk edge at which rst_n=1.
REQ-032 Asserting rst_n mid-count SHALL discard any pending load or count.

Verification
REQ-033 WIDTH=4, MODULUS=16, up=1, enp=ent=1 for 17 edges from reset -> q goes 1..15, then 0; rco=1 only while q=15; wrap=1 in the cycle q=0.
REQ-034 MODULUS=10, load d=12, then count up -> q=12, 0, 1 with wrap never asserted; then count down from 0 -> q=9 with wrap=1.
REQ-035 clr_n=0 with load_n=0 and d=5 on the same edge -> q=0; load_n=0, enp=0 -> q=5; enp=1, ent=0 -> q holds 5 and rco=0.
REQ-036 Two instances cascaded (rco0->ent1, WIDTH=4, MODULUS=10, up=1) counting 100 edges from reset -> q1:q0 = 0:0 and one wrap pulse on stage 1.
REQ-037 rst_n pulsed low between clk edges while q=7 -> q=0 immediately; held count resumes at 1 on the first edge after release.
REQ-038 up toggled on the edge with q=0, enp=ent=1 -> up=1 gives q=1; up=0 gives q=MODULUS-1 with wrap=1.
